// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback stage and a long-latency unit. Pipeline writes win by default.
// Unit results are queued in a small FIFO and use idle slots. A starvation
// counter forces a one-cycle pipeline stall (DRAIN) so that queued results
// always retire.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   p_valid/p_addr/p_data    pipeline WB write request (held while pipe_stall)
//   u_valid/u_addr/u_data    unit result; accepted when u_valid && u_ready
//   u_ready                  FIFO has space (from registered count only)
//   pipe_stall               freeze pipeline for the current cycle
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   fifo_count               current FIFO occupancy
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          p_valid,
  input  logic [ADDR_W-1:0]             p_addr,
  input  logic [DATA_W-1:0]             p_data,
  input  logic                          u_valid,
  output logic                          u_ready,
  input  logic [ADDR_W-1:0]             u_addr,
  input  logic [DATA_W-1:0]             u_data,
  output logic                          pipe_stall,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [ST_W-1:0]  STARVE_MAXC = ST_W'(STARVE_MAX);
  localparam logic [ST_W-1:0]  STARVE_LAST = ST_W'(STARVE_MAX - 1);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ST_W-1:0]    starve_q, starve_d;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

  // FIFO storage; head is read combinationally so a pop can grant the
  // entry in the same cycle. Contents need no reset: pointers define validity.
  logic [ADDR_W-1:0]  addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]  data_mem [FIFO_DEPTH];

  logic               push;
  logic               pop;
  logic               grant;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_data;

  // Space check uses only registered occupancy: a full FIFO never accepts a
  // push in the same cycle it pops.
  assign u_ready    = (count_q < DEPTH_C);
  assign fifo_count = count_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    pipe_stall = 1'b0;
    pop        = 1'b0;
    grant      = 1'b0;
    g_addr     = '0;
    g_data     = '0;
    push       = u_valid && u_ready;

    case (state_q)
      ST_NORMAL: begin
        if (p_valid) begin
          grant  = 1'b1;
          g_addr = p_addr;
          g_data = p_data;
        end else if (count_q != '0) begin
          grant  = 1'b1;
          pop    = 1'b1;
          g_addr = addr_mem[rd_ptr_q];
          g_data = data_mem[rd_ptr_q];
        end
        // Head has now waited STARVE_MAX cycles: steal the next slot.
        if (!pop && (count_q != '0) && (starve_q == STARVE_LAST)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Pipeline request is ignored; the stalled WB stage re-presents it.
        pipe_stall = 1'b1;
        state_d    = ST_NORMAL;
        if (count_q != '0) begin
          grant  = 1'b1;
          pop    = 1'b1;
          g_addr = addr_mem[rd_ptr_q];
          g_data = data_mem[rd_ptr_q];
        end
      end
      default: state_d = ST_NORMAL;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop || (count_q == '0)) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAXC) begin
      starve_d = starve_q + 1'b1;
    end

    // A grant to $zero is consumed but never reaches the register file.
    if (grant) begin
      rf_we_d    = (g_addr != '0);
      rf_waddr_d = g_addr;
      rf_wdata_d = g_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_NORMAL;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= u_addr;
      data_mem[wr_ptr_q] <= u_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (default parameters:
// DATA_W=32, ADDR_W=5, FIFO_DEPTH=2, STARVE_MAX=4).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, i.e. they show the state produced by that edge.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        u_valid;
  logic        u_ready;
  logic [4:0]  u_addr;
  logic [31:0] u_data;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  regfile_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data),
    .u_valid(u_valid), .u_ready(u_ready), .u_addr(u_addr), .u_data(u_data),
    .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("check %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected write-port contents for one cycle.
  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"},   32'(rf_we),    32'(we));
    chk({tag, ".addr"}, 32'(rf_waddr), 32'(a));
    chk({tag, ".data"}, rf_wdata,      d);
  endtask

  initial begin
    rst = 1'b1; p_valid = 1'b0; p_addr = '0; p_data = '0;
    u_valid = 1'b0; u_addr = '0; u_data = '0;

    // Reset state
    tick();
    chk_rf("reset", 1'b0, 5'd0, 32'h0);
    chk("reset.stall", 32'(pipe_stall), 32'd0);
    chk("reset.count", 32'(fifo_count), 32'd0);
    chk("reset.u_ready", 32'(u_ready), 32'd1);
    rst = 1'b0;
    tick();
    $display("txn reset: count=%0d u_ready=%0b", fifo_count, u_ready);

    // Pipeline-only write: one-cycle latency, then addr/data hold.
    p_valid = 1'b1; p_addr = 5'd8; p_data = 32'hDEADBEEF;
    tick();
    chk_rf("pipe.wr", 1'b1, 5'd8, 32'hDEADBEEF);
    p_valid = 1'b0;
    tick();
    chk_rf("pipe.idle_hold", 1'b0, 5'd8, 32'hDEADBEEF);
    $display("txn pipe write addr=8 data=deadbeef");

    // Idle-slot drain of a unit result.
    u_valid = 1'b1; u_addr = 5'd9; u_data = 32'h1234;
    tick();
    u_valid = 1'b0;
    chk("idle.count1", 32'(fifo_count), 32'd1);
    chk("idle.we0", 32'(rf_we), 32'd0);
    tick();
    chk_rf("idle.wr", 1'b1, 5'd9, 32'h1234);
    chk("idle.count0", 32'(fifo_count), 32'd0);
    chk("idle.stall", 32'(pipe_stall), 32'd0);
    tick();
    chk("idle.we_after", 32'(rf_we), 32'd0);
    $display("txn idle drain addr=9 data=1234");

    // Starvation: pipeline busy every cycle, head waits STARVE_MAX cycles.
    u_valid = 1'b1; u_addr = 5'd10; u_data = 32'hAA;
    p_valid = 1'b1; p_addr = 5'd5; p_data = 32'h55;
    tick();                                   // cycle 1
    u_valid = 1'b0;
    chk("starve.c1.count", 32'(fifo_count), 32'd1);
    chk("starve.c1.stall", 32'(pipe_stall), 32'd0);
    tick();                                   // cycle 2
    chk_rf("starve.c2", 1'b1, 5'd5, 32'h55);
    chk("starve.c2.stall", 32'(pipe_stall), 32'd0);
    tick();                                   // cycle 3
    chk_rf("starve.c3", 1'b1, 5'd5, 32'h55);
    chk("starve.c3.stall", 32'(pipe_stall), 32'd0);
    tick();                                   // cycle 4
    chk_rf("starve.c4", 1'b1, 5'd5, 32'h55);
    chk("starve.c4.stall", 32'(pipe_stall), 32'd0);
    tick();                                   // cycle 5
    chk_rf("starve.c5", 1'b1, 5'd5, 32'h55);
    chk("starve.c5.stall", 32'(pipe_stall), 32'd1);
    chk("starve.c5.count", 32'(fifo_count), 32'd1);
    tick();                                   // cycle 6
    chk_rf("starve.c6", 1'b1, 5'd10, 32'hAA);
    chk("starve.c6.stall", 32'(pipe_stall), 32'd0);
    chk("starve.c6.count", 32'(fifo_count), 32'd0);
    tick();                                   // cycle 7
    chk_rf("starve.c7", 1'b1, 5'd5, 32'h55);
    p_valid = 1'b0;
    tick();
    chk("starve.c8.we", 32'(rf_we), 32'd0);
    $display("txn starvation drain addr=10 data=aa");

    // Full FIFO: third push is held off, drain keeps push order.
    p_valid = 1'b1; p_addr = 5'd7; p_data = 32'h77;
    u_valid = 1'b1; u_addr = 5'd11; u_data = 32'hB11;
    tick();                                   // cycle 1
    chk("full.c1.count", 32'(fifo_count), 32'd1);
    chk("full.c1.u_ready", 32'(u_ready), 32'd1);
    u_addr = 5'd12; u_data = 32'hB12;
    tick();                                   // cycle 2
    chk("full.c2.count", 32'(fifo_count), 32'd2);
    chk("full.c2.u_ready", 32'(u_ready), 32'd0);
    u_addr = 5'd13; u_data = 32'hB13;
    tick();                                   // cycle 3
    chk("full.c3.count", 32'(fifo_count), 32'd2);
    tick();                                   // cycle 4
    chk("full.c4.count", 32'(fifo_count), 32'd2);
    chk("full.c4.stall", 32'(pipe_stall), 32'd0);
    tick();                                   // cycle 5: DRAIN pops 11
    chk("full.c5.stall", 32'(pipe_stall), 32'd1);
    chk("full.c5.u_ready", 32'(u_ready), 32'd0);
    tick();                                   // cycle 6: 13 pushed now
    chk_rf("full.c6", 1'b1, 5'd11, 32'hB11);
    chk("full.c6.count", 32'(fifo_count), 32'd1);
    chk("full.c6.u_ready", 32'(u_ready), 32'd1);
    tick();                                   // cycle 7
    u_valid = 1'b0; p_valid = 1'b0;
    chk_rf("full.c7", 1'b1, 5'd7, 32'h77);
    chk("full.c7.count", 32'(fifo_count), 32'd2);
    tick();                                   // cycle 8
    chk_rf("full.c8", 1'b1, 5'd12, 32'hB12);
    chk("full.c8.count", 32'(fifo_count), 32'd1);
    tick();                                   // cycle 9
    chk_rf("full.c9", 1'b1, 5'd13, 32'hB13);
    chk("full.c9.count", 32'(fifo_count), 32'd0);
    $display("txn full fifo drain order 11,12,13");

    // Zero register: both grants consumed, nothing written.
    tick();
    p_valid = 1'b1; p_addr = 5'd0; p_data = 32'h1111;
    u_valid = 1'b1; u_addr = 5'd0; u_data = 32'h99;
    tick();
    p_valid = 1'b0; u_valid = 1'b0;
    chk("zero.c1.we", 32'(rf_we), 32'd0);
    chk("zero.c1.count", 32'(fifo_count), 32'd1);
    tick();
    chk("zero.c2.we", 32'(rf_we), 32'd0);
    chk("zero.c2.count", 32'(fifo_count), 32'd0);
    tick();
    chk("zero.c3.we", 32'(rf_we), 32'd0);
    $display("txn zero-register grants consumed");

    // Reset with two queued entries: they must never be written.
    p_valid = 1'b1; p_addr = 5'd3; p_data = 32'h33;
    u_valid = 1'b1; u_addr = 5'd14; u_data = 32'hE14;
    tick();
    u_addr = 5'd15; u_data = 32'hE15;
    tick();
    chk("rst2.count", 32'(fifo_count), 32'd2);
    rst = 1'b1; p_valid = 1'b0; u_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk_rf("rst2", 1'b0, 5'd0, 32'h0);
    chk("rst2.count0", 32'(fifo_count), 32'd0);
    chk("rst2.u_ready", 32'(u_ready), 32'd1);
    chk("rst2.stall", 32'(pipe_stall), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst2.no_stale_we", 32'(rf_we), 32'd0);
      chk("rst2.count_stays0", 32'(fifo_count), 32'd0);
    end
    $display("txn reset discards queued entries");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (regWrite/writeReg/writeData) between two requesters:
  - the in-order pipeline writeback stage;
  - a long-latency unit (mult/div or load) that finishes out of band.
- Pipeline writes win by default. Unit results wait in a small FIFO.
- A starvation counter briefly stalls the pipeline so queued unit results always drain.
- Sits between the WB stage / long-latency unit and the register file.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, unit-result buffer entries (power of 2, >=2)
- STARVE_MAX, 4, cycles the FIFO head may wait before the pipeline is stalled (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- p_valid  in  1  pipeline WB write request this cycle; held unchanged while pipe_stall=1
- p_addr  in  ADDR_W  pipeline destination register
- p_data  in  DATA_W  pipeline write data
- u_valid  in  1  unit result valid
- u_ready  out  1  unit result accepted when u_valid&&u_ready
- u_addr  in  ADDR_W  unit destination register
- u_data  in  DATA_W  unit result data
- pipe_stall  out  1  freeze pipeline (WB holds its request)
- rf_we  out  1  to register file regWrite
- rf_waddr  out  ADDR_W  to register file writeReg
- rf_wdata  out  DATA_W  to register file writeData
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: one clk edge with rst=1 gives:
  - FIFO empty, starve counter 0, state NORMAL;
  - rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, fifo_count=0, u_ready=1.
- Reset mid-operation discards all queued entries. No write is issued for them.
- u_ready = (fifo_count < FIFO_DEPTH), from registered state only. No same-cycle pop-then-push when full.
- Push on u_valid&&u_ready. The entry is visible at the FIFO head the next cycle.
- States and grants:
  - NORMAL:
    - p_valid=1: grant pipeline.
    - p_valid=0 and fifo_count>0: grant FIFO head and pop it.
    - otherwise: no grant.
  - DRAIN:
    - pipe_stall=1 (combinational from state).
    - p_valid is ignored; the pipeline holds it.
    - Grant FIFO head and pop it. Next state is NORMAL.
- Starve counter, updated each edge:
  - Set to 0 if a pop occurs or fifo_count==0.
  - Otherwise increment, saturating at STARVE_MAX.
- Transition NORMAL->DRAIN when all hold at the edge:
  - counter==STARVE_MAX-1;
  - fifo_count>0;
  - no pop this cycle.
  So the FIFO head has waited STARVE_MAX cycles.
- Write port is registered, latency 1. The grant in cycle N drives rf_we/rf_waddr/rf_wdata in cycle N+1, and the register file commits at the end of cycle N+1.
- With no grant: rf_we=0; rf_waddr and rf_wdata hold their last values.
- Address 0: the grant is consumed (pop or pipeline ack) but rf_we=0. $zero is never written.
- Simultaneous push and pop: both occur and count is unchanged. This is allowed only when count<FIFO_DEPTH, per the u_ready rule.
- Ordering:
  - FIFO entries are written strictly in push order.
  - WAW between the pipeline and queued unit results is prevented upstream by issue logic. The arbiter does no address compare.
- pipe_stall is asserted for exactly one cycle per DRAIN entry. Two consecutive DRAIN cycles require the counter to re-reach the threshold.

Test Plan:
- Reset with FIFO holding 2 entries -> next cycle fifo_count=0, u_ready=1, rf_we=0, pipe_stall=0; no stale write ever appears.
- Pipeline only: p_valid=1, p_addr=8, p_data=0xDEADBEEF in cycle 3 -> rf_we=1, rf_waddr=8, rf_wdata=0xDEADBEEF in cycle 4 only.
- Idle-slot drain: u push (addr 9, 0x1234) in cycle 0, p_valid=0 -> grant in cycle 1, rf_we=1, addr 9, data 0x1234 in cycle 2; fifo_count back to 0; pipe_stall never set.
- Starvation, STARVE_MAX=4: u push (addr 10, 0xAA) in cycle 0, p_valid held 1 with addr 5 throughout ->
  - cycles 1-4: rf writes are addr 5 (in cycles 2-5);
  - pipe_stall=1 in cycle 5 only;
  - rf_waddr=10, rf_wdata=0xAA in cycle 6;
  - pipeline write resumes in cycle 7.
- Full FIFO: three u_valid pushes (addrs 11, 12, 13) in cycles 0-2 with p_valid=1 -> u_ready=0 in cycle 2, third held; drain order is 11, 12, 13; count never exceeds 2.
- Zero register: p_addr=0 and a u entry with addr 0 -> both consumed (pop occurs, fifo_count decrements), rf_we stays 0 in the following cycles.
